// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: opcodes, widths and the fetch queue entry.
package cpu_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OPC_JMP = 4'hF;
    localparam logic [3:0] OPC_BNE = 4'hE;

    // One fetched instruction together with the byte address it came from
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Force a byte address onto a 16-bit word boundary
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries between fetch and decode.
// The head entry is read straight from the storage flops, so decode sees
// registered data that holds still while it stalls.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       entry_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    // A push into a full queue is only legal when the head leaves the same cycle
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = entry_reg[rd_ptr_reg];

    // Per-slot storage: each slot captures the incoming entry when it is the write target
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg[gi] <= push_entry;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, folds unconditional JMPs without
// passing them to decode, buffers fetched words and applies execute redirects.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h000,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               jmp_folded
);

    logic [ADDR_W-1:0] pc_reg;
    logic              jmp_folded_reg;

    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              q_full;
    logic              q_empty;
    logic              accept;
    logic              slot_free;
    logic              fetch;
    logic              is_jmp;
    logic              push;
    logic              unused_redirect_lsb;

    // Bit 0 of the redirect target is dropped by word alignment
    assign unused_redirect_lsb = redirect_pc[0];

    assign imem_addr  = pc_reg;
    assign id_valid   = !q_empty;
    assign id_instr   = head.instr;
    assign id_pc      = head.pc;
    assign jmp_folded = jmp_folded_reg;

    // Decode takes the head whenever both sides agree, even during a redirect
    assign accept     = id_valid && id_ready;
    // A full queue still has room if its head is leaving this cycle
    assign slot_free  = !q_full || accept;
    assign fetch      = !redirect_valid && slot_free;
    assign is_jmp     = (imem_data[15:12] == OPC_JMP);
    assign push       = fetch && !is_jmp;

    assign push_entry.instr = imem_data;
    assign push_entry.pc    = pc_reg;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (accept),
        .flush      (redirect_valid),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty)
    );

    // PC update: redirect beats a JMP fold, which beats sequential advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            pc_reg <= word_align(redirect_pc);
        end else if (fetch && is_jmp) begin
            pc_reg <= {imem_data[10:0], 1'b0};
        end else if (fetch) begin
            pc_reg <= pc_reg + ADDR_W'(2);
        end
    end

    // One-cycle marker for each JMP consumed by fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jmp_folded_reg <= 1'b0;
        end else begin
            jmp_folded_reg <= fetch && is_jmp;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for the
// straight-line / stall / redirect stream plus short hand-written sequences.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [11:0] imem_addr;
    logic [15:0] imem_data;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [11:0] id_pc;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        jmp_folded;

    logic [15:0] mem [0:2047];

    int checks;
    int errors;

    instr_fetch_unit #(
        .RESET_PC (12'h000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .jmp_folded     (jmp_folded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers combinationally
    always_comb imem_data = mem[imem_addr[11:1]];

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [11:0] rpc;
        logic [11:0] e_addr;
        logic        e_valid;
        logic        chk_data;
        logic [15:0] e_instr;
        logic [11:0] e_pc;
        logic        e_jf;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 12'h000;

        // ---------------- JMP fold from reset ----------------
        clear_mem();
        mem[12'h000 >> 1] = 16'hF0C8;
        mem[12'h190 >> 1] = 16'h0688;
        mem[12'h192 >> 1] = 16'h1234;
        id_ready = 1'b1;
        do_reset();
        check("rst addr", {4'h0, imem_addr}, 16'h0000);
        check("rst valid", {15'h0, id_valid}, 16'h0000);
        check("rst instr", id_instr, 16'h0000);
        check("rst pc", {4'h0, id_pc}, 16'h0000);
        check("rst jf", {15'h0, jmp_folded}, 16'h0000);
        step();
        check("jmp addr", {4'h0, imem_addr}, 16'h0190);
        check("jmp jf", {15'h0, jmp_folded}, 16'h0001);
        check("jmp valid", {15'h0, id_valid}, 16'h0000);
        step();
        check("jmp tgt valid", {15'h0, id_valid}, 16'h0001);
        check("jmp tgt instr", id_instr, 16'h0688);
        check("jmp tgt pc", {4'h0, id_pc}, 16'h0190);
        check("jmp jf drop", {15'h0, jmp_folded}, 16'h0000);
        check("jmp next addr", {4'h0, imem_addr}, 16'h0192);
        $display("seq jmp_fold done");

        // ---------------- table-driven stream ----------------
        clear_mem();
        mem[12'h000 >> 1] = 16'h04E0;
        mem[12'h002 >> 1] = 16'h14C6;
        mem[12'h004 >> 1] = 16'h24E0;
        mem[12'h006 >> 1] = 16'h34E0;
        mem[12'h008 >> 1] = 16'h44E0;
        mem[12'h100 >> 1] = 16'hF0C8;
        mem[12'h3FC >> 1] = 16'h5555;
        mem[12'h3FE >> 1] = 16'h6666;
        //             rdy   rv    rpc      addr     vld  chk  instr     pc       jf
        vecs[0]  = '{1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 16'h0000, 12'h000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 12'h000, 12'h002, 1'b1, 1'b1, 16'h04E0, 12'h000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 12'h000, 12'h004, 1'b1, 1'b1, 16'h04E0, 12'h000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 12'h000, 12'h004, 1'b1, 1'b1, 16'h04E0, 12'h000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 12'h000, 12'h004, 1'b1, 1'b1, 16'h04E0, 12'h000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 12'h000, 12'h006, 1'b1, 1'b1, 16'h14C6, 12'h002, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 12'h000, 12'h008, 1'b1, 1'b1, 16'h24E0, 12'h004, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 12'h000, 12'h00A, 1'b1, 1'b1, 16'h34E0, 12'h006, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 12'h3FD, 12'h00A, 1'b1, 1'b1, 16'h34E0, 12'h006, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 12'h000, 12'h3FC, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 12'h000, 12'h3FE, 1'b1, 1'b1, 16'h5555, 12'h3FC, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 12'h000, 12'h400, 1'b1, 1'b1, 16'h6666, 12'h3FE, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 12'h000, 12'h402, 1'b1, 1'b1, 16'h0000, 12'h400, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 12'h101, 12'h000, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 12'h008, 12'h100, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 12'h000, 12'h008, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 12'h000, 12'h00A, 1'b1, 1'b1, 16'h44E0, 12'h008, 1'b0};
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            id_ready       = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            check($sformatf("v%0d addr", i), {4'h0, imem_addr}, {4'h0, vecs[i].e_addr});
            check($sformatf("v%0d valid", i), {15'h0, id_valid}, {15'h0, vecs[i].e_valid});
            check($sformatf("v%0d jf", i), {15'h0, jmp_folded}, {15'h0, vecs[i].e_jf});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d instr", i), id_instr, vecs[i].e_instr);
                check($sformatf("v%0d pc", i), {4'h0, id_pc}, {4'h0, vecs[i].e_pc});
            end
            $display("vec %0d: rdy=%b rv=%b addr=%h valid=%b instr=%h pc=%h jf=%b",
                     i, vecs[i].rdy, vecs[i].rv, imem_addr, id_valid, id_instr, id_pc, jmp_folded);
            step();
        end
        redirect_valid = 1'b0;

        // ---------------- PC wrap at top of memory ----------------
        clear_mem();
        mem[12'hFFE >> 1] = 16'h04E0;
        mem[12'h000 >> 1] = 16'h14C6;
        id_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFE;
        step();
        redirect_valid = 1'b0;
        check("wrap addr ffe", {4'h0, imem_addr}, 16'h0FFE);
        step();
        check("wrap addr 000", {4'h0, imem_addr}, 16'h0000);
        check("wrap instr", id_instr, 16'h04E0);
        check("wrap pc", {4'h0, id_pc}, 16'h0FFE);
        step();
        check("wrap next instr", id_instr, 16'h14C6);
        check("wrap next pc", {4'h0, id_pc}, 16'h0000);
        $display("seq wrap done");

        // ---------------- JMP to itself ----------------
        clear_mem();
        mem[0] = 16'hF000;
        id_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("self%0d addr", k), {4'h0, imem_addr}, 16'h0000);
            check($sformatf("self%0d jf", k), {15'h0, jmp_folded}, 16'h0001);
            check($sformatf("self%0d valid", k), {15'h0, id_valid}, 16'h0000);
        end
        $display("seq self_jmp done");

        // ---------------- async reset mid-stream ----------------
        clear_mem();
        mem[0] = 16'h04E0;
        mem[1] = 16'h14C6;
        mem[2] = 16'h24E0;
        id_ready = 1'b0;
        do_reset();
        step();
        step();
        check("pre-rst valid", {15'h0, id_valid}, 16'h0001);
        check("pre-rst addr", {4'h0, imem_addr}, 16'h0004);
        #3 rst = 1'b1;
        #1;
        check("async rst valid", {15'h0, id_valid}, 16'h0000);
        check("async rst addr", {4'h0, imem_addr}, 16'h0000);
        check("async rst instr", id_instr, 16'h0000);
        $display("seq async_reset done");
        step();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage that drives the instruction port of the unified 4 KB memory (12-bit byte address, 16-bit words) and consumes the instruction word it returns.
- Holds the PC and folds unconditional JMP (opcode 4'hF) locally.
- Buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake.
- Accepts branch redirects (BNE resolution) from execute.

Parameters:
- RESET_PC, 12'h000, byte address fetched first after reset.
- DEPTH, 2, instruction queue entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  12  instruction byte address to memory; bit 0 is always 0.
- imem_data  in  16  instruction word; combinational response to imem_addr, same cycle.
- id_valid  out  1  queue head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  16  head instruction word.
- id_pc  out  12  byte address of the head instruction.
- redirect_valid  in  1  execute requests a PC change (taken BNE).
- redirect_pc  in  12  new byte address; bit 0 is ignored and forced to 0.
- jmp_folded  out  1  one-cycle pulse when a JMP is consumed by fetch.

Behaviour:
- Reset (async): pc=RESET_PC; queue empty; id_valid=0; id_instr=16'h0000; id_pc=12'h000; jmp_folded=0.
- imem_addr = pc, combinational from the pc register.
- Fetch fires in a cycle when redirect_valid=0 and the queue has a free slot. A slot counts as free if the queue is not full, or if it is full and id_ready&&id_valid this cycle.
- On fetch, when imem_data[15:12]==4'hF (JMP):
  - Word is not enqueued.
  - pc <= {imem_data[10:0],1'b0} (2×imm, truncated to 12 bits).
  - jmp_folded=1 next cycle.
  - Example: F0C8 → pc=0x190.
- On fetch, any other opcode:
  - Enqueue {imem_data, pc}.
  - pc <= pc+2, wrapping modulo 4096 (0xFFE → 0x000).
- No fetch: pc holds.
- Dequeue when id_valid && id_ready. Head advances at the clock edge.
- Enqueue and dequeue may occur in the same cycle when full: occupancy unchanged, no data loss.
- Queue outputs are registered. An instruction enqueued at edge n is visible on id_* after edge n (latency 1 cycle from imem_addr presentation).
- id_instr and id_pc hold stable while id_valid=1 && id_ready=0.
- Redirect (redirect_valid=1) has highest priority:
  - Queue flushed.
  - pc <= {redirect_pc[11:1],1'b0}.
  - No fetch or enqueue that cycle.
  - Any dequeue that cycle is still counted as accepted by decode.
  - id_valid=0 the following cycle.
  - Target fetched the following cycle; its instruction appears on id_* one cycle after that (redirect at edge n → target at id after edge n+2).
- Redirect overrides a JMP fold in the same cycle: no fold, no jmp_folded pulse.
- Back-to-back redirects: the last one wins.
- JMP to itself (e.g. F000 at address 0): pc stays 0, jmp_folded asserts every cycle, queue drains and stays empty. Legal, no hang detection.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.
- Queue states: EMPTY (id_valid=0), PARTIAL, FULL (fetch stalls unless dequeue that cycle). Tracked by wr/rd pointers plus count.

Decomposition:
- Shared package cpu_pkg:
  - OPC_JMP=4'hF, OPC_BNE=4'hE.
  - ADDR_W=12, INSTR_W=16.
  - typedef fetch_entry_t {instr[15:0], pc[11:0]}.
- Sub-module fetch_queue: a parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty.
- PC and fold logic live in the top.

Test Plan:
- Reset, memory[0]=F0C8, memory[0x190]=0688, id_ready=1 → cycle 1 imem_addr=0x000; jmp_folded pulses; imem_addr=0x190; id_instr=0688, id_pc=0x190 one cycle later; F0C8 never appears on id_*.
- Straight-line 04E0,14C6,24E0 at 0x000/0x002/0x004, id_ready=0 → queue fills with 2 entries, imem_addr stalls at 0x004. Then id_ready=1 → outputs 04E0, 14C6, 24E0 in order, one per cycle, with no gaps.
- Queue full and id_ready=1 in the same cycle → simultaneous push/pop; occupancy stays 2; sequence is contiguous.
- Redirect with redirect_pc=0x3FD while 2 entries are queued → id_valid=0 next cycle; imem_addr=0x3FC; id_pc=0x3FC appears one cycle later.
- pc=0xFFE holding non-JMP 04E0 → next imem_addr=0x000.
- rst asserted mid-stream with id_valid=1 → id_valid=0 and imem_addr=RESET_PC immediately, before the next clk edge.
